// File: rtl/shift_seq_ctrl.sv
// Serial shift controller: applies one 1-bit shift per cycle, shamt times,
// for SLL/SRL/SRA/ROL, with a one-cycle done pulse and a busy flag.
module shift_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]         OP_SLL   = 2'b00;
  localparam logic [1:0]         OP_SRL   = 2'b01;
  localparam logic [1:0]         OP_SRA   = 2'b10;
  localparam logic [1:0]         OP_ROL   = 2'b11;
  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [1:0]         op_r;
  logic [SHAMT_W-1:0] count_r;

  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  shift_one = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  shift_one = {v[WIDTH-2:0], v[WIDTH-1]};
      default: shift_one = v;
    endcase
  endfunction

  // Controller FSM; busy and done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 2'b00;
      count_r <= CNT_ZERO;
      result  <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_r    <= op;
            result  <= data_in;
            count_r <= shamt;
            if (shamt != CNT_ZERO) begin
              state_r <= ST_SHIFT;
              busy    <= 1'b1;
              done    <= 1'b0;
            end else begin
              // Zero shift goes straight to DONE with the operand as result.
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          result  <= shift_one(op_r, result);
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written
// corner sequences, and randomized operations against an arithmetic reference.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  shift_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole shift computed in one go from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic signed [31:0] sd;
    int                 n;
    n  = int'(s);
    sd = d;
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return sd >>> n;
      default: return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
    endcase
  endfunction

  // Drive a start for one cycle; inputs are then scrambled to prove they are not re-sampled.
  task automatic launch(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    op = o; data_in = d; shamt = s; start = 1'b1;
    step();
    start = 1'b0;
    op = 2'($urandom); data_in = $urandom; shamt = 5'($urandom);
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      step();
      lat++;
    end
  endtask

  task automatic end_check(input string nm, input logic [4:0] s, input logic [31:0] exp,
                           input int lat, input int nbusy);
    check({nm, " latency"}, 32'(lat), 32'(s));
    check({nm, " busy_cycles"}, 32'(nbusy), 32'(s));
    check({nm, " done"}, {31'd0, done}, 32'd1);
    check({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({nm, " result"}, result, exp);
  endtask

  task automatic after_check(input string nm, input logic [31:0] exp);
    step();
    check({nm, " done_pulse_end"}, {31'd0, done}, 32'd0);
    check({nm, " result_hold"}, result, exp);
  endtask

  initial begin
    int lat, nb, nb2, ndone;
    logic [1:0]  ro;
    logic [31:0] rd, rexp;
    logic [4:0]  rs;
    bit          chain;

    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[3]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[5]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[6]  = '{2'b11, 32'h1234_5678, 5'd4,  32'h2345_6781};
    vecs[7]  = '{2'b10, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF};
    vecs[8]  = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000};
    vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    vecs[10] = '{2'b11, 32'h8000_0000, 5'd31, 32'h4000_0000};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; data_in = 32'h0; shamt = 5'd0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].data, vecs[i].shamt);
      wait_done(lat, nb);
      end_check($sformatf("vec%0d", i), vecs[i].shamt, vecs[i].exp, lat, nb);
      after_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back: second start issued during the done cycle of the first.
    launch(2'b11, 32'h8000_0001, 5'd1);
    wait_done(lat, nb);
    end_check("b2b first", 5'd1, 32'h0000_0003, lat, nb);
    launch(2'b00, 32'h0000_0003, 5'd2);
    check("b2b no_idle busy", {31'd0, busy}, 32'd1);
    check("b2b no_idle done", {31'd0, done}, 32'd0);
    wait_done(lat, nb);
    end_check("b2b second", 5'd2, 32'h0000_000C, lat, nb);
    after_check("b2b second", 32'h0000_000C);

    // Start while busy is ignored.
    launch(2'b00, 32'h0000_0001, 5'd8);
    nb = 0;
    repeat (3) begin
      if (busy === 1'b1) nb++;
      step();
    end
    op = 2'b01; shamt = 5'd1; data_in = 32'hFFFF_FFFF; start = 1'b1;
    if (busy === 1'b1) nb++;
    step();
    start = 1'b0;
    wait_done(lat, nb2);
    end_check("busy_start", 5'd8, 32'h0000_0100, lat + 4, nb + nb2);
    after_check("busy_start", 32'h0000_0100);

    // Reset during the third SHIFT cycle of a 10-step shift.
    launch(2'b00, 32'h0000_0001, 5'd10);
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'h0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check("midreset no_done", 32'(ndone), 32'd0);
    launch(2'b01, 32'h0000_F000, 5'd12);
    wait_done(lat, nb);
    end_check("post_reset", 5'd12, 32'h0000_000F, lat, nb);
    after_check("post_reset", 32'h0000_000F);

    // Randomized operations, sometimes chained back-to-back.
    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rd = $urandom;
      rs = (i % 8 == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom);
      rexp = ref_shift(ro, rd, rs);
      if (!chain) begin
        repeat ($urandom_range(0, 2)) step();
      end
      launch(ro, rd, rs);
      wait_done(lat, nb);
      end_check($sformatf("rand%0d", i), rs, rexp, lat, nb);
      chain = ($urandom_range(0, 1) == 1);
      if (!chain) after_check($sformatf("rand%0d", i), rexp);
    end
    if (chain) after_check("rand_tail", rexp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
